stream_capture_buffer: RTL and testbench
========================================

// Module: stream_capture_buffer
// PURPOSE
//  Sink end of the 64-bit Avalon-ST sample stream produced by the processing chain (e.g. the moving-average filter).
//  Captures a programmed number of valid samples into on-chip RAM after a start pulse, then holds them.
//  Host/NIOS reads the stored samples back through a simple pipelined read port, as 32-bit halves.
// PARAMETERS
//  DEPTH   4096  samples stored; power of two; must fit available RAM blocks
//  ADDR_W  12    log2(DEPTH)
// PORTS
//  clock             in   1         single clock for all logic
//  reset             in   1         asynchronous, active-high
//  enable            in   1         0: input stream ignored; FSM and read port still operate
//  start             in   1         1-cycle pulse; arms a new capture
//  n_samples         in   16        samples to capture; 0 or >DEPTH clamps to DEPTH; sampled at start
//  data_valid        in   1         Avalon-ST valid (no backpressure; sink always accepts)
//  data              in   64        signed sample
//  rd_address        in   ADDR_W+1  [ADDR_W:1] sample index, [0] half (0 = bits 31:0, 1 = bits 63:32)
//  rd_read           in   1         read strobe; one read per asserted cycle
//  rd_readdata       out  32        read data
//  rd_readdatavalid  out  1         qualifies rd_readdata
//  busy              out  1         1 while in CAPTURE
//  capture_done      out  1         1 while in DONE
//  samples_stored    out  16        samples written since the last start
// BEHAVIOUR
//  Reset: state IDLE; busy=0, capture_done=0, samples_stored=0, rd_readdata=0, rd_readdatavalid=0, wr_ptr=0.
//   RAM is not cleared.
//  FSM IDLE->CAPTURE on start. CAPTURE->DONE on the write of sample n_eff. DONE->CAPTURE on start.
//  start entry (from any state, incl. CAPTURE = restart):
//   - latch n_eff from n_samples; wr_ptr=0; samples_stored=0.
//   - a sample valid in the same cycle as start is NOT stored; first store is the next cycle.
//  Write: in CAPTURE with enable && data_valid, mem[wr_ptr]<=data; wr_ptr++; samples_stored++.
//   - last write (samples_stored becomes n_eff): next cycle state=DONE, busy=0, capture_done=1.
//   - valid samples arriving in IDLE/DONE, or with enable=0, are dropped silently.
//  Read: accepted in every state; fixed latency 2.
//   - rd_read at cycle t -> rd_readdatavalid=1 and rd_readdata valid at t+2.
//   - back-to-back reads give one result per cycle, in order.
//   - read of a location written in the same cycle returns the old data (read-before-write).
//   - reads beyond samples_stored return stale RAM contents; no error flag.
//  Reset mid-capture: return to IDLE immediately; an in-flight read is dropped (readdatavalid=0).
//  Widths: data stored unmodified, full 64 bits; wr_ptr is ADDR_W+1 bits so n_eff=DEPTH does not wrap early.
// CONFIGURATION
//  CAPTURE_SKIP_EN defined:
//   - extra input port skip_count[15:0], latched at start.
//   - the first skip_count accepted samples after start are discarded (filter fill time, MxN).
//   - discarded samples do not count in samples_stored; busy=1 during the skip phase.
//   - skip_count=0 behaves as the base build.
//  CAPTURE_SKIP_EN undefined: no skip_count port; storage starts at the first accepted sample after start.
// TESTING
//  1. reset=1 pulse mid-stream -> all outputs 0, state IDLE; after release, data_valid alone stores nothing (samples_stored=0).
//  2. n_samples=8, start, then data=1..10 valid every cycle -> capture_done after 8th.
//     - samples_stored=8; reads 0..15 return 1..8 as lo/hi halves (hi=0); samples 9,10 dropped.
//  3. data=64'hFFFF_FFFF_8000_0001 at index 0; rd_read addr 0 then 1 back-to-back
//     -> readdatavalid at t+2 and t+3 with 32'h8000_0001, 32'hFFFF_FFFF.
//  4. n_samples=0 -> captures 4096 samples; capture_done only after the 4096th; index 4095 readable, index 0 not overwritten.
//  5. start and data_valid same cycle, valid gaps and enable=0 mid-capture (n_samples=4)
//     -> the sample coincident with start is not stored; gated samples are not stored; exactly 4 stored.
//  6. CAPTURE_SKIP_EN, skip_count=3, n_samples=2, data=10..14
//     -> stored 13,14; restart via start in CAPTURE resets samples_stored to 0.

Source files
------------

// File: rtl/stream_capture_buffer.sv
// Captures a programmed number of 64-bit stream samples into RAM and serves them back as 32-bit halves.
// Define CAPTURE_SKIP_EN to add a skip_count input that discards the first samples after each start.
module stream_capture_buffer #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              start,
  input  logic [15:0]       n_samples,
`ifdef CAPTURE_SKIP_EN
  input  logic [15:0]       skip_count,
`endif
  input  logic              data_valid,
  input  logic [63:0]       data,
  input  logic [ADDR_W:0]   rd_address,
  input  logic              rd_read,
  output logic [31:0]       rd_readdata,
  output logic              rd_readdatavalid,
  output logic              busy,
  output logic              capture_done,
  output logic [15:0]       samples_stored
);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_N = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] n_eff_q, n_eff_d;
  logic [ADDR_W:0] n_clamped;
  logic            wr_en;
  logic            skipping;

  logic [63:0]     mem [DEPTH];
  logic [63:0]     rd_word_q;
  logic            rd_half_q, rd_half_d;
  logic            rd_pend_q, rd_pend_d;
  logic [31:0]     rd_readdata_q, rd_readdata_d;
  logic            rd_valid_q, rd_valid_d;

`ifdef CAPTURE_SKIP_EN
  logic [15:0]     skip_q, skip_d;
  assign skipping = (skip_q != 16'd0);
`else
  assign skipping = 1'b0;
`endif

  // Zero or an oversized request means "fill the whole buffer".
  always_comb begin
    if (n_samples == 16'd0 || 32'(n_samples) > DEPTH)
      n_clamped = DEPTH_N;
    else
      n_clamped = n_samples[ADDR_W:0];
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    n_eff_d  = n_eff_q;
    wr_en    = 1'b0;
`ifdef CAPTURE_SKIP_EN
    skip_d   = skip_q;
`endif
    if (start) begin
      state_d  = CAPTURE;
      wr_ptr_d = '0;
      n_eff_d  = n_clamped;
`ifdef CAPTURE_SKIP_EN
      skip_d   = skip_count;
`endif
    end else if (state_q == CAPTURE && enable && data_valid) begin
      if (skipping) begin
`ifdef CAPTURE_SKIP_EN
        skip_d = skip_q - 16'd1;
`endif
      end else begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (wr_ptr_d == n_eff_q)
          state_d = DONE;
      end
    end
  end

  always_comb begin
    rd_pend_d     = rd_read;
    rd_half_d     = rd_address[0];
    rd_valid_d    = rd_pend_q;
    rd_readdata_d = rd_half_q ? rd_word_q[63:32] : rd_word_q[31:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      n_eff_q       <= DEPTH_N;
      rd_pend_q     <= 1'b0;
      rd_half_q     <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_readdata_q <= '0;
`ifdef CAPTURE_SKIP_EN
      skip_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      n_eff_q       <= n_eff_d;
      rd_pend_q     <= rd_pend_d;
      rd_half_q     <= rd_half_d;
      rd_valid_q    <= rd_valid_d;
      rd_readdata_q <= rd_readdata_d;
`ifdef CAPTURE_SKIP_EN
      skip_q        <= skip_d;
`endif
    end
  end

  // Unreset RAM with a registered read; a same-edge write leaves the old word in rd_word_q.
  always_ff @(posedge clock) begin
    if (wr_en)
      mem[wr_ptr_q[ADDR_W-1:0]] <= data;
    rd_word_q <= mem[rd_address[ADDR_W:1]];
  end

  assign rd_readdata      = rd_readdata_q;
  assign rd_readdatavalid = rd_valid_q;
  assign busy             = (state_q == CAPTURE);
  assign capture_done     = (state_q == DONE);
  assign samples_stored   = 16'(wr_ptr_q);

endmodule

// File: tb/tb_stream_capture_buffer.sv
// Directed testbench for stream_capture_buffer: status checks plus a read scoreboard that
// verifies read data, ordering and the two-cycle read latency.
module tb_stream_capture_buffer;

  localparam int DEPTH  = 4096;
  localparam int ADDR_W = 12;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              start;
  logic [15:0]       n_samples;
`ifdef CAPTURE_SKIP_EN
  logic [15:0]       skip_count;
`endif
  logic              data_valid;
  logic [63:0]       data;
  logic [ADDR_W:0]   rd_address;
  logic              rd_read;
  logic [31:0]       rd_readdata;
  logic              rd_readdatavalid;
  logic              busy;
  logic              capture_done;
  logic [15:0]       samples_stored;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  typedef struct {
    logic [31:0] value;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t head;

  stream_capture_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .start            (start),
    .n_samples        (n_samples),
`ifdef CAPTURE_SKIP_EN
    .skip_count       (skip_count),
`endif
    .data_valid       (data_valid),
    .data             (data),
    .rd_address       (rd_address),
    .rd_read          (rd_read),
    .rd_readdata      (rd_readdata),
    .rd_readdatavalid (rd_readdatavalid),
    .busy             (busy),
    .capture_done     (capture_done),
    .samples_stored   (samples_stored)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // Read monitor: every valid beat must match the oldest outstanding read, on its due cycle.
  always @(negedge clock) begin
    if (rd_readdatavalid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_read actual=%h required=no_valid cycle=%0d", rd_readdata, cycle);
      end else begin
        head = sb.pop_front();
        if (rd_readdata !== head.value || cycle != head.due) begin
          errors++;
          $display("[TB] FAIL %s actual=%h@%0d required=%h@%0d",
                   head.name, rd_readdata, cycle, head.value, head.due);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic [15:0] n, input logic dv,
                               input logic [63:0] d, input logic en);
    start      = st;
    n_samples  = n;
    data_valid = dv;
    data       = d;
    enable     = en;
    step();
    start      = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic sendSample(input logic [63:0] d);
    applyStimulus(1'b0, n_samples, 1'b1, d, 1'b1);
  endtask

  task automatic issueRead(input logic [ADDR_W:0] addr, input logic [31:0] expv, input string name);
    exp_t e;
    e.value = expv;
    e.due   = cycle + 2;
    e.name  = name;
    sb.push_back(e);
    rd_read    = 1'b1;
    rd_address = addr;
  endtask

  task automatic readExpect(input logic [ADDR_W:0] addr, input logic [31:0] expv, input string name);
    issueRead(addr, expv, name);
    step();
    rd_read = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; start = 1'b0; n_samples = 16'd0;
    data_valid = 1'b0; data = '0; rd_address = '0; rd_read = 1'b0;
`ifdef CAPTURE_SKIP_EN
    skip_count = 16'd0;
`endif
    step(); step();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(capture_done), 32'd0);
    checkOutput("reset_valid", 32'(rd_readdatavalid), 32'd0);
    reset = 1'b0;
    step();

    // Reset in the middle of a capture with a read in flight
    applyStimulus(1'b1, 16'd8, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < 3; i++) sendSample(64'(i + 100));
    checkOutput("pre_reset_stored", 32'(samples_stored), 32'd3);
    rd_read = 1'b1; rd_address = '0;
    step();
    rd_read = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_busy", 32'(busy), 32'd0);
    checkOutput("reset_mid_stored", 32'(samples_stored), 32'd0);
    checkOutput("reset_mid_rdata", rd_readdata, 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) sendSample(64'(i + 200));
    checkOutput("post_reset_stored", 32'(samples_stored), 32'd0);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);

    // Capture 8 of 10 samples
    applyStimulus(1'b1, 16'd8, 1'b0, 64'd0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      sendSample(64'(i));
      if (i == 4) checkOutput("cap8_busy_mid", 32'(busy), 32'd1);
      if (i == 7) checkOutput("cap8_done_early", 32'(capture_done), 32'd0);
      if (i == 8) checkOutput("cap8_done", 32'(capture_done), 32'd1);
    end
    checkOutput("cap8_stored", 32'(samples_stored), 32'd8);
    checkOutput("cap8_busy_end", 32'(busy), 32'd0);
    for (int a = 0; a < 16; a++)
      readExpect((ADDR_W+1)'(a), (a % 2 == 0) ? 32'(a / 2 + 1) : 32'd0, $sformatf("cap8_rd%0d", a));

    // Signed sample split into halves, back-to-back reads
    applyStimulus(1'b1, 16'd2, 1'b0, 64'd0, 1'b1);
    sendSample(64'hFFFF_FFFF_8000_0001);
    sendSample(64'h0123_4567_89AB_CDEF);
    readExpect(13'd0, 32'h8000_0001, "half_lo");
    readExpect(13'd1, 32'hFFFF_FFFF, "half_hi");
    readExpect(13'd3, 32'h0123_4567, "half_hi1");

    // Read and write of index 0 on the same edge returns the old word
    applyStimulus(1'b1, 16'd1, 1'b0, 64'd0, 1'b1);
    issueRead(13'd0, 32'h8000_0001, "rbw_old");
    sendSample(64'hAAAA_BBBB_CCCC_DDDD);
    rd_read = 1'b0;
    readExpect(13'd0, 32'hCCCC_DDDD, "rbw_new");
    checkOutput("rbw_done", 32'(capture_done), 32'd1);

    // n_samples = 0 fills the whole buffer
    applyStimulus(1'b1, 16'd0, 1'b0, 64'd0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      sendSample({32'(i) ^ 32'h5A5A_0000, 32'(i + 1000)});
      if (i == DEPTH - 2) begin
        checkOutput("full_done_early", 32'(capture_done), 32'd0);
        checkOutput("full_stored_m1", 32'(samples_stored), 32'(DEPTH - 1));
      end
    end
    checkOutput("full_done", 32'(capture_done), 32'd1);
    checkOutput("full_stored", 32'(samples_stored), 32'(DEPTH));
    sendSample(64'hDEAD_BEEF_DEAD_BEEF);
    readExpect(13'd0, 32'd1000, "full_idx0_lo");
    readExpect(13'd1, 32'h5A5A_0000, "full_idx0_hi");
    readExpect(13'(2 * (DEPTH - 1)), 32'(DEPTH - 1 + 1000), "full_last_lo");
    readExpect(13'(2 * (DEPTH - 1) + 1), 32'h5A5A_0FFF, "full_last_hi");

    // Restart during CAPTURE, coincident sample, gaps and enable gating
    applyStimulus(1'b1, 16'd4, 1'b0, 64'd0, 1'b1);
    sendSample(64'd40);
    sendSample(64'd41);
    checkOutput("restart_pre_stored", 32'(samples_stored), 32'd2);
    applyStimulus(1'b1, 16'd4, 1'b1, 64'd50, 1'b1);
    checkOutput("restart_stored", 32'(samples_stored), 32'd0);
    checkOutput("restart_busy", 32'(busy), 32'd1);
    sendSample(64'd51);
    applyStimulus(1'b0, 16'd4, 1'b0, 64'd0, 1'b1);
    sendSample(64'd52);
    applyStimulus(1'b0, 16'd4, 1'b1, 64'd53, 1'b0);
    checkOutput("gated_stored", 32'(samples_stored), 32'd2);
    sendSample(64'd54);
    sendSample(64'd55);
    sendSample(64'd56);
    checkOutput("gap_stored", 32'(samples_stored), 32'd4);
    checkOutput("gap_done", 32'(capture_done), 32'd1);
    readExpect(13'd0, 32'd51, "gap_rd0");
    readExpect(13'd2, 32'd52, "gap_rd1");
    readExpect(13'd4, 32'd54, "gap_rd2");
    readExpect(13'd6, 32'd55, "gap_rd3");
    readExpect(13'd8, 32'd1004, "gap_stale4");

`ifdef CAPTURE_SKIP_EN
    // Skip phase discards the first samples but still reports busy
    skip_count = 16'd3;
    applyStimulus(1'b1, 16'd2, 1'b0, 64'd0, 1'b1);
    skip_count = 16'd0;
    for (int i = 10; i <= 14; i++) begin
      sendSample(64'(i));
      if (i == 12) begin
        checkOutput("skip_busy", 32'(busy), 32'd1);
        checkOutput("skip_stored0", 32'(samples_stored), 32'd0);
      end
    end
    checkOutput("skip_stored", 32'(samples_stored), 32'd2);
    checkOutput("skip_done", 32'(capture_done), 32'd1);
    readExpect(13'd0, 32'd13, "skip_rd0");
    readExpect(13'd2, 32'd14, "skip_rd1");
`endif

    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL read_drain actual=%0d_pending required=0", sb.size());
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
